// File: rtl/gray_histogram_pkg.sv
// rtl/gray_histogram_pkg.sv - shared state type and helpers for gray_histogram
package gray_hist_pkg;

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_DUMP  = 1'b1
  } hist_state_e;

  // Increment v, holding at the all-ones value of a w-bit counter
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [63:0] max_v;
    max_v = (64'd1 << w) - 64'd1;
    if ({32'd0, v} >= max_v) return v;
    return v + 32'd1;
  endfunction

  // Map a pixel value onto a bin index, clamping overlarge values into the top bin
  function automatic logic [31:0] clamp_idx(input logic [31:0] d, input int bits);
    logic [63:0] n;
    n = 64'd1 << bits;
    if ({32'd0, d} < n) return d;
    return 32'(n - 64'd1);
  endfunction

endpackage

// File: rtl/gray_histogram_if.sv
// rtl/gray_histogram_if.sv - pixel input and histogram output streams of gray_histogram
interface gray_hist_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int COUNT_WIDTH = 16
);
  logic [DATA_WIDTH-1:0]  s_tdata;
  logic                   s_tvalid;
  logic                   s_tready;
  logic                   s_tlast;
  logic [COUNT_WIDTH-1:0] m_tdata;
  logic                   m_tvalid;
  logic                   m_tready;
  logic                   m_tlast;

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tlast
  );

  modport master (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tlast
  );
endinterface

// File: rtl/gray_histogram_bins.sv
// rtl/gray_histogram_bins.sv - bin counter array with increment, clear and async read
module gray_hist_bins
  import gray_hist_pkg::*;
#(
  parameter int BIN_BITS    = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inc_en_i,
  input  logic [BIN_BITS-1:0]    inc_idx_i,
  input  logic                   clr_en_i,
  input  logic [BIN_BITS-1:0]    clr_idx_i,
  input  logic [BIN_BITS-1:0]    rd_idx_i,
  output logic [COUNT_WIDTH-1:0] rd_data_o
);
  localparam int NUM_BINS = 2 ** BIN_BITS;

  logic [COUNT_WIDTH-1:0] bin_q [NUM_BINS];
  logic [COUNT_WIDTH-1:0] inc_val_d;

  assign inc_val_d = COUNT_WIDTH'(sat_inc(32'(bin_q[inc_idx_i]), COUNT_WIDTH));
  assign rd_data_o = bin_q[rd_idx_i];

  // Clear wins over increment; the controller never asserts both in one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BINS; i++) bin_q[i] <= '0;
    end else if (clr_en_i) begin
      bin_q[clr_idx_i] <= '0;
    end else if (inc_en_i) begin
      bin_q[inc_idx_i] <= inc_val_d;
    end
  end

endmodule

// File: rtl/gray_histogram.sv
// rtl/gray_histogram.sv - per-frame gray histogram with streamed dump (optional GRAY_HIST_PIXCOUNT_EN)
module gray_histogram
  import gray_hist_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int BIN_BITS    = 8,
  parameter int COUNT_WIDTH = 16
) (
  input logic        clk,
  input logic        rst,
  gray_hist_if.slave hist_io
);
  localparam int NUM_BINS = 2 ** BIN_BITS;
`ifdef GRAY_HIST_PIXCOUNT_EN
  localparam logic [BIN_BITS:0] LAST_IDX = (BIN_BITS + 1)'(NUM_BINS);
`else
  localparam logic [BIN_BITS:0] LAST_IDX = (BIN_BITS + 1)'(NUM_BINS - 1);
`endif

  hist_state_e            state_q, state_d;
  logic [BIN_BITS:0]      rd_ptr_q, rd_ptr_d;
  logic                   s_fire, m_fire, is_last, clr_en;
  logic [BIN_BITS-1:0]    bin_idx;
  logic [COUNT_WIDTH-1:0] bin_rd, dump_val;

  assign hist_io.s_tready = !rst && (state_q == ST_ACCUM);
  assign hist_io.m_tvalid = (state_q == ST_DUMP);
  assign s_fire  = hist_io.s_tvalid && hist_io.s_tready;
  assign m_fire  = hist_io.m_tvalid && hist_io.m_tready;
  assign is_last = (rd_ptr_q == LAST_IDX);
  assign bin_idx = BIN_BITS'(clamp_idx(32'(hist_io.s_tdata), BIN_BITS));
  // The pointer's top bit is only ever set on the extra total beat
  assign clr_en  = m_fire && !rd_ptr_q[BIN_BITS];

  gray_hist_bins #(
    .BIN_BITS   (BIN_BITS),
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_bins (
    .clk      (clk),
    .rst      (rst),
    .inc_en_i (s_fire),
    .inc_idx_i(bin_idx),
    .clr_en_i (clr_en),
    .clr_idx_i(rd_ptr_q[BIN_BITS-1:0]),
    .rd_idx_i (rd_ptr_q[BIN_BITS-1:0]),
    .rd_data_o(bin_rd)
  );

`ifdef GRAY_HIST_PIXCOUNT_EN
  logic [COUNT_WIDTH-1:0] total_q, total_d;

  // Frame pixel total: counts accepted pixels, cleared when its dump beat is taken
  always_comb begin
    total_d = total_q;
    if (m_fire && is_last) total_d = '0;
    else if (s_fire) total_d = COUNT_WIDTH'(sat_inc(32'(total_q), COUNT_WIDTH));
  end

  // Pixel total register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) total_q <= '0;
    else     total_q <= total_d;
  end

  assign dump_val = rd_ptr_q[BIN_BITS] ? total_q : bin_rd;
`else
  assign dump_val = bin_rd;
`endif

  assign hist_io.m_tdata = hist_io.m_tvalid ? dump_val : '0;
  assign hist_io.m_tlast = hist_io.m_tvalid && is_last;

  // ACCUM until the frame's last pixel, then walk every bin out before accepting more
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    case (state_q)
      ST_ACCUM: begin
        if (s_fire && hist_io.s_tlast) begin
          state_d  = ST_DUMP;
          rd_ptr_d = '0;
        end
      end
      ST_DUMP: begin
        if (m_fire) begin
          if (is_last) begin
            state_d  = ST_ACCUM;
            rd_ptr_d = '0;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end
      default: begin
        state_d  = ST_ACCUM;
        rd_ptr_d = '0;
      end
    endcase
  end

  // FSM and read pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_ACCUM;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule
